// File: rtl/ld_clk_switch_ctrl_if.sv
// Request/status bundle between the control-register side and the load-clock
// switch sequencer. The master drives requests; the slave is the sequencer.
interface ld_clk_switch_ctrl_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_sel;
   logic       req_en;
   logic       req_gate;
   logic [2:0] ld_div_sel;
   logic       ld_clk_en;
   logic       ld_clk_gate;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output req_valid, req_sel, req_en, req_gate,
      input  req_ready, ld_div_sel, ld_clk_en, ld_clk_gate, busy, done, err
   );

   modport slave (
      input  req_valid, req_sel, req_en, req_gate,
      output req_ready, ld_div_sel, ld_clk_en, ld_clk_gate, busy, done, err
   );
endinterface

// File: rtl/ld_clk_switch_ctrl.sv
// Load-clock switch sequencer: gates ld_clk off, drains the divider, changes
// the divider select, lets it settle, then applies the requested en/gate.
// Same-select requests complete in one cycle; selects above 4 raise err.
module ld_clk_switch_ctrl #(
   parameter int DRAIN_CYCLES  = 12,
   parameter int SETTLE_CYCLES = 8,
   parameter int CNT_W         = 8
) (
   input  logic                 CRCU_CLK,
   input  logic                 CRCU_RST_N,
   ld_clk_switch_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      SETTLE
   } state_t;

   localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [2:0]       SEL_MAX     = 3'd4;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       lat_sel;
   logic             lat_en;
   logic             lat_gate;

   // Sequencer FSM; every output is a register updated alongside the state.
   always_ff @(posedge CRCU_CLK) begin
      if (!CRCU_RST_N) begin
         state           <= IDLE;
         cnt             <= '0;
         lat_sel         <= '0;
         lat_en          <= 1'b0;
         lat_gate        <= 1'b1;
         bus.ld_div_sel  <= '0;
         bus.ld_clk_en   <= 1'b0;
         bus.ld_clk_gate <= 1'b1;
         bus.req_ready   <= 1'b1;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.err         <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_sel  <= bus.req_sel;
                  lat_en   <= bus.req_en;
                  lat_gate <= bus.req_gate;
                  if (bus.req_sel > SEL_MAX) begin
                     bus.err <= 1'b1;
                  end else if (bus.req_sel == bus.ld_div_sel) begin
                     bus.ld_clk_en   <= bus.req_en;
                     bus.ld_clk_gate <= bus.req_gate;
                     bus.done        <= 1'b1;
                  end else begin
                     // Always drain, even if the clock is already stopped.
                     bus.ld_clk_en   <= 1'b0;
                     bus.ld_clk_gate <= 1'b1;
                     cnt             <= DRAIN_LOAD;
                     state           <= DRAIN;
                     bus.req_ready   <= 1'b0;
                     bus.busy        <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  bus.ld_div_sel <= lat_sel;
                  cnt            <= SETTLE_LOAD;
                  state          <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  bus.ld_clk_en   <= lat_en;
                  bus.ld_clk_gate <= lat_gate;
                  bus.done        <= 1'b1;
                  state           <= IDLE;
                  bus.req_ready   <= 1'b1;
                  bus.busy        <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
               bus.busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
